// File: rtl/fetch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_pc_ctrl
//   Fetch-stage program-counter controller for an instruction memory with a
//   one-cycle synchronous read. It generates the fetch address, tags the word
//   appearing on the memory read port with its address, marks which words are
//   real instructions, and counts instructions handed downstream.
//
// Ports
//   clk          in   system clock, rising edge active
//   rst          in   asynchronous reset, active low
//   stall        in   hazard-unit hold request for the fetch stage
//   redirect     in   taken branch/jump from execute
//   redirect_pc  in   [31:0] branch/jump target address
//   pc           out  [31:0] fetch address to instruction memory
//   pc_plus4     out  [31:0] pc + 4 (combinational)
//   pc_d         out  [31:0] address of the word on the memory read port
//   instr_valid  out  memory read data is a real instruction
//   misalign_err out  one-cycle pulse: last redirect target not word aligned
//   fetch_count  out  [31:0] count of valid instructions handed downstream
// -----------------------------------------------------------------------------
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_d,
  output logic        instr_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] redirect_tgt;

  // Low address bits are dropped; a misaligned target is flagged, not trapped.
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  // Wraps from 32'hFFFF_FFFC to 0 through natural 32-bit overflow.
  assign pc_plus4 = pc + 32'd4;

  // ---- Stage 0: fetch address (redirect > stall > increment) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_tgt;
    end else if (!stall) begin
      pc <= pc_plus4;
    end
  end

  // ---- Stage 1: address tag of the word on the memory read port ----
  // Loads every edge, stall included: under stall pc holds, so pc_d
  // settles on the same address the memory keeps re-reading.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_d <= RESET_PC;
    end else begin
      pc_d <= pc;
    end
  end

  // Validity FSM. The word arriving on the cycle after a redirect edge was
  // fetched from the old path, so BUBBLE marks exactly that one cycle invalid.
  // BOOT also yields to a redirect so the reset-address word is discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        BOOT, RUN, BUBBLE: begin
          if (redirect) begin
            state       <= BUBBLE;
            instr_valid <= 1'b0;
          end else begin
            state       <= RUN;
            instr_valid <= 1'b1;
          end
        end
        default: begin
          state       <= BOOT;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect & (|redirect_pc[1:0]);
    end
  end

  // A word is consumed downstream when it is valid and the stage is not held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= 32'd0;
    end else if ((state == RUN) && !stall) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_d;
  logic        instr_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  fetch_pc_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .pc_d         (pc_d),
    .instr_valid  (instr_valid),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic        vld;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: the DUT presents a new fetch state after every edge; sample it
  // on the falling edge and compare with the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".pc"},           pc,                   e.pc);
      chk({e.name, ".pc_plus4"},     pc_plus4,             e.pc + 32'd4);
      chk({e.name, ".pc_d"},         pc_d,                 e.pc_d);
      chk({e.name, ".instr_valid"},  {31'd0, instr_valid}, {31'd0, e.vld});
      chk({e.name, ".misalign_err"}, {31'd0, misalign_err},{31'd0, e.mis});
      chk({e.name, ".fetch_count"},  fetch_count,          e.cnt);
    end
  end

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic step(input string name, input logic st, input logic rd,
                      input logic [31:0] rpc, input logic [31:0] e_pc,
                      input logic [31:0] e_pcd, input logic e_v,
                      input logic e_m, input logic [31:0] e_cnt);
    exp_t e;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    e.name = name; e.pc = e_pc; e.pc_d = e_pcd;
    e.vld = e_v; e.mis = e_m; e.cnt = e_cnt;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ".pc"},           pc,                    32'h0);
    chk({name, ".pc_plus4"},     pc_plus4,              32'h4);
    chk({name, ".pc_d"},         pc_d,                  32'h0);
    chk({name, ".instr_valid"},  {31'd0, instr_valid},  32'h0);
    chk({name, ".misalign_err"}, {31'd0, misalign_err}, 32'h0);
    chk({name, ".fetch_count"},  fetch_count,           32'h0);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b1;

    //     name        st rd rpc            pc             pc_d           v  m  cnt
    step("boot1",      0, 0, 32'h0,         32'h4,         32'h0,         1, 0, 32'd0);
    step("boot2",      0, 0, 32'h0,         32'h8,         32'h4,         1, 0, 32'd1);
    step("boot3",      0, 0, 32'h0,         32'hC,         32'h8,         1, 0, 32'd2);
    step("boot4",      0, 0, 32'h0,         32'h10,        32'hC,         1, 0, 32'd3);
    step("redir",      0, 1, 32'h100,       32'h100,       32'h10,        0, 0, 32'd4);
    step("redir_tgt",  0, 0, 32'h0,         32'h104,       32'h100,       1, 0, 32'd4);
    step("to_20",      0, 1, 32'h1C,        32'h1C,        32'h104,       0, 0, 32'd5);
    step("at_20",      0, 0, 32'h0,         32'h20,        32'h1C,        1, 0, 32'd5);
    step("stall1",     1, 0, 32'h0,         32'h20,        32'h20,        1, 0, 32'd5);
    step("stall2",     1, 0, 32'h0,         32'h20,        32'h20,        1, 0, 32'd5);
    step("stall3",     1, 0, 32'h0,         32'h20,        32'h20,        1, 0, 32'd5);
    step("unstall",    0, 0, 32'h0,         32'h24,        32'h20,        1, 0, 32'd6);
    step("st_rd_mis",  1, 1, 32'h203,       32'h200,       32'h24,        0, 1, 32'd6);
    step("st_rd_tgt",  0, 0, 32'h0,         32'h204,       32'h200,       1, 0, 32'd6);
    step("b2b_40",     0, 1, 32'h40,        32'h40,        32'h204,       0, 0, 32'd7);
    step("b2b_80",     0, 1, 32'h80,        32'h80,        32'h40,        0, 0, 32'd7);
    step("b2b_tgt",    0, 0, 32'h0,         32'h84,        32'h80,        1, 0, 32'd7);
    step("b2b_next",   0, 0, 32'h0,         32'h88,        32'h84,        1, 0, 32'd8);
    step("mis_101",    0, 1, 32'h101,       32'h100,       32'h88,        0, 1, 32'd9);
    step("bub_stall",  1, 0, 32'h0,         32'h100,       32'h100,       1, 0, 32'd9);
    step("after_bs",   0, 0, 32'h0,         32'h104,       32'h100,       1, 0, 32'd10);
    step("to_top",     0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h104,       0, 1, 32'd11);
    step("wrap",       0, 0, 32'h0,         32'h0,         32'hFFFF_FFFC, 1, 0, 32'd11);
    step("post_wrap",  0, 0, 32'h0,         32'h4,         32'h0,         1, 0, 32'd12);
    step("into_bub",   0, 1, 32'h300,       32'h300,       32'h4,         0, 0, 32'd13);

    // Mid-BUBBLE asynchronous reset: outputs must clear before any edge.
    redirect = 1'b1; redirect_pc = 32'h500;
    rst = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    redirect = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    #1;
    chk_reset_vals("rst_held");
    rst = 1'b1;

    step("rel1",       0, 0, 32'h0,         32'h4,         32'h0,         1, 0, 32'd0);
    step("rel2",       0, 0, 32'h0,         32'h8,         32'h4,         1, 0, 32'd1);

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, expected %0d more checks", exp_q.size());
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_pc_ctrl.md
FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: boot fetch address (word-aligned).
REQ-002 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  input  1  hazard-unit hold request for the fetch stage.
REQ-005 SHALL have port redirect  input  1  taken branch/jump from execute.
REQ-006 SHALL have port redirect_pc  input  32  branch/jump target address.
REQ-007 SHALL have port pc  output  32  fetch address to instruction memory (word index = pc[31:2]).
REQ-008 SHALL have port pc_plus4  output  32  pc + 4, combinational.
REQ-009 SHALL have port pc_d  output  32  address of the instruction currently on the memory read-data output.
REQ-010 SHALL have port instr_valid  output  1  memory read data is a real instruction.
REQ-011 SHALL have port misalign_err  output  1  one-cycle pulse: a redirect target was not word-aligned.
REQ-012 SHALL have port fetch_count  output  32  count of valid instructions handed downstream.

Function
REQ-013 SHALL assume instruction memory with one-cycle synchronous read: data at cycle n+1 = mem[pc at cycle n edge].
REQ-014 SHALL update pc each rising edge with priority redirect > stall > increment.
REQ-015 On redirect, pc SHALL load {redirect_pc[31:2],2'b00}.
REQ-016 On stall without redirect, pc SHALL hold.
REQ-017 Otherwise pc SHALL load pc+4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000 silently.
REQ-018 pc_d SHALL load pc on every rising edge, including stall cycles, so it always tags the memory read data.
REQ-019 SHALL implement FSM states BOOT, RUN, BUBBLE; instr_valid = (state == RUN).
REQ-020 BOOT: entered on reset; next edge -> BUBBLE if redirect, else -> RUN (stall does not block).
REQ-021 RUN: redirect -> BUBBLE; otherwise stay RUN.
REQ-022 BUBBLE: redirect -> BUBBLE (again discard in-flight word); otherwise -> RUN.
REQ-023 Consequence: after any redirect, instr_valid SHALL be 0 for exactly the one cycle in which the stale word is on the memory output; the target's word SHALL then appear with instr_valid = 1.
REQ-024 Under stall in RUN, pc, pc_d and state SHALL hold, so the memory re-reads the same word and the output stays stable and valid.
REQ-025 misalign_err SHALL be 1 for exactly the cycle after an edge where redirect = 1 and redirect_pc[1:0] != 0; otherwise 0.
REQ-026 fetch_count SHALL increment by 1 on each edge where state == RUN and stall == 0, wrapping modulo 2^32.
REQ-027 Redirect and stall in the same cycle SHALL behave as redirect alone, but no fetch_count increment is made if stall = 1.

Reset
REQ-028 While rst = 0, asynchronously: pc = RESET_PC, pc_d = RESET_PC, state = BOOT, instr_valid = 0, misalign_err = 0, fetch_count = 0.
REQ-029 Reset assertion mid-operation, including during BUBBLE or stall, SHALL discard all in-flight state immediately; there is no pending redirect after release.
REQ-030 First rising edge after rst release SHALL perform a normal update per REQ-014.

Verification
REQ-031 Reset release, no stall/redirect, 4 edges -> pc 0,4,8,C,10; instr_valid 0 then 1; pc_d lags pc by one edge; fetch_count = 3 after edge 4.
REQ-032 In RUN at pc = 0x10, redirect = 1, redirect_pc = 0x100 -> next pc = 0x100, instr_valid = 0 for one cycle, then pc_d = 0x100 with instr_valid = 1.
REQ-033 In RUN, stall held 3 cycles at pc = 0x20 -> pc and pc_d constant, instr_valid = 1, fetch_count unchanged; pc = 0x24 on the first edge after release.
REQ-034 stall = 1 and redirect = 1 with redirect_pc = 0x203 -> pc = 0x200, misalign_err = 1 for exactly one cycle, instr_valid 0 for one cycle.
REQ-035 Back-to-back redirects to 0x40 then 0x80 -> instr_valid 0 for two cycles; first valid pc_d = 0x80.
REQ-036 pc = 0xFFFF_FFFC with no stall -> pc wraps to 0x0; rst pulsed low mid-BUBBLE -> all outputs reach reset values without a clock edge.
